serial_addsub16: RTL and testbench

//  Multi-cycle 16-bit two's-complement adder/subtractor. Computes one 4-bit slice per

---
 rtl/serial_addsub16.sv | 115 +++++++++++
 tb/tb_serial_addsub16.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub16.sv
// rtl/serial_addsub16.sv - multi-cycle 16-bit adder/subtractor, one 4-bit slice per clock
module serial_addsub16 #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bx_q, bx_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [SLICE-1:0] x4, y4;
   logic [SLICE:0]   sum5;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      bx_d    = bx_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      x4   = a_q[int'(cnt_q) * SLICE +: SLICE];
      y4   = bx_q[int'(cnt_q) * SLICE +: SLICE];
      sum5 = {1'b0, x4} + {1'b0, y4} + {{SLICE{1'b0}}, carry_q};

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               // subtract as a + ~b + 1: invert b here, inject the +1 as the initial carry
               bx_d    = b ^ {WIDTH{op}};
               carry_d = op;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            s_d[int'(cnt_q) * SLICE +: SLICE] = sum5[SLICE-1:0];
            carry_d = sum5[SLICE];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               cout_d  = sum5[SLICE];
               // carry into the MSB is recovered from the MSB sum bit and its operands
               ovf_d   = sum5[SLICE] ^ (x4[SLICE-1] ^ y4[SLICE-1] ^ sum5[SLICE-1]);
               zero_d  = (s_d == '0);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         bx_q    <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub16.sv
// tb/tb_serial_addsub16.sv - directed-vector bench for serial_addsub16
module tb_serial_addsub16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] s;
   logic        cout;
   logic        ovf;
   logic        zero;

   int checks = 0;
   int errors = 0;

   serial_addsub16 dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   // Issues one operation from a negedge and returns at the negedge where done is seen.
   task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                         output int lat);
      op    = op_i;
      a     = a_i;
      b     = b_i;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; op = 1'b1; a = 16'h1234; b = 16'h0001;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, s, cout, ovf, zero} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state got busy=%b done=%b s=%h cout=%b ovf=%b zero=%b want all 0",
                  busy, done, s, cout, ovf, zero);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_start_ignored busy=%b want 0", busy);
      end
   endtask

   task automatic test_vec(input string name, input logic op_i, input logic [15:0] a_i,
                           input logic [15:0] b_i, input logic [15:0] exp_s,
                           input logic exp_c, input logic exp_v, input logic exp_z);
      int lat;
      run_op(op_i, a_i, b_i, lat);
      checks++;
      if (lat !== 4 || done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_latency lat=%0d done=%b busy=%b want lat=4 done=1 busy=1",
                  name, lat, done, busy);
      end
      checks++;
      if ({s, cout, ovf, zero} !== {exp_s, exp_c, exp_v, exp_z}) begin
         errors++;
         $display("FAIL %s_result s=%h c=%b v=%b z=%b want s=%h c=%b v=%b z=%b",
                  name, s, cout, ovf, zero, exp_s, exp_c, exp_v, exp_z);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || s !== exp_s) begin
         errors++;
         $display("FAIL %s_hold done=%b busy=%b s=%h want done=0 busy=0 s=%h",
                  name, done, busy, s, exp_s);
      end
   endtask

   task automatic test_add;
      test_vec("add_t1", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sub;
      test_vec("sub_borrow", 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow;
      test_vec("sub_ovf", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      test_vec("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_zero;
      test_vec("sub_zero", 1'b1, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 1'b1);
      test_vec("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_handshake;
      int pulses = 0;
      int cyc = 0;
      op = 1'b0; a = 16'h1234; b = 16'h0FCD; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      // second RUN cycle: conflicting request with different operands
      op = 1'b1; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (done === 1'b1) pulses++;
      checks++;
      if (done !== 1'b1 || s !== 16'h2201 || cout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL hs_result done=%b s=%h c=%b v=%b want done=1 s=2201 c=0 v=0",
                  done, s, cout, ovf);
      end
      // request during DONE must be dropped
      op = 1'b0; a = 16'h4000; b = 16'h4000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) pulses++;
      checks++;
      if (busy !== 1'b0 || s !== 16'h2201) begin
         errors++;
         $display("FAIL hs_done_ignored busy=%b s=%h want busy=0 s=2201", busy, s);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL hs_single_pulse pulses=%0d want 1", pulses);
      end
      // first IDLE cycle after DONE: accepted
      op = 1'b0; a = 16'h0001; b = 16'h0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL hs_idle_accept busy=%b want 1", busy);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 4 || s !== 16'h0002 || zero !== 1'b0) begin
         errors++;
         $display("FAIL hs_b2b lat=%0d s=%h zero=%b want lat=4 s=0002 zero=0", cyc, s, zero);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int lat;
      int pulses = 0;
      run_op(1'b0, 16'hFFFF, 16'h0002, lat);
      checks++;
      if (s !== 16'h0001 || cout !== 1'b1) begin
         errors++;
         $display("FAIL rm_setup s=%h c=%b want s=0001 c=1", s, cout);
      end
      @(negedge clk);
      op = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      // third RUN cycle
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, done, s, cout, ovf, zero} !== 21'd0) begin
         errors++;
         $display("FAIL rm_cleared busy=%b done=%b s=%h c=%b v=%b z=%b want all 0",
                  busy, done, s, cout, ovf, zero);
      end
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL rm_no_done pulses=%0d want 0", pulses);
      end
      test_vec("rm_fresh", 1'b1, 16'h1234, 16'h0234, 16'h1000, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      @(negedge clk);
      test_reset;
      test_add;
      test_sub;
      test_overflow;
      test_zero;
      test_handshake;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
